vga_scan_ctrl: RTL and testbench

- Read-side sequencer for the 256x240 VGA frame memory.
- Generates 640x480@60 VGA timing from the system clock using a pixel-enable divider.
- Drives the frame memory's read row/col with 2x pixel/line doubling so the 256x240 image fills a 512x480 window.
- Registers returned palette indices, with hsync/vsync/de delayed to match, and emits frame and vblank status to the PPU side.

---
 rtl/vga_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// Read-side scan sequencer for the 256x240 frame memory: 640x480@60 timing, 2x pixel/line
// doubling, registered palette output. Define VGA_CENTER_EN to centre the 512-wide image.
module vga_scan_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] mem_row,
    output logic [9:0] mem_col,
    input  logic [7:0] mem_data,
    output logic [7:0] pix_out,
    output logic       de,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start,
    output logic       in_vblank
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int IMG_W = 512;
`ifdef VGA_CENTER_EN
    localparam int X0 = 64;
`else
    localparam int X0 = 0;
`endif

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        pix_en;
    logic [10:0] h_off;
    logic        in_img;
    logic        de0_d, de0_q;
    logic        hs0_d, hs0_q;
    logic        vs0_d, vs0_q;
    logic [7:0]  pix_out_d, pix_out_q;
    logic        de_d, de_q;
    logic        hsync_n_d, hsync_n_q;
    logic        vsync_n_d, vsync_n_q;
    logic        frame_start_d, frame_start_q;
    logic        in_vblank_d, in_vblank_q;

    always_comb begin
        pix_en        = (CLK_DIV <= 1) || (div_cnt_q == DIV_LAST);
        div_cnt_d     = pix_en ? 4'd0 : div_cnt_q + 4'd1;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d       = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
        in_vblank_d = (v_cnt_d >= V_VIS_C);
    end

    // Left of X0 the 11-bit difference wraps far above IMG_W, so one compare bounds both sides.
    always_comb begin
        h_off   = {1'b0, h_cnt_q} - 11'(X0);
        in_img  = (h_off < 11'(IMG_W)) && (v_cnt_q < V_VIS_C);
        mem_row = in_img ? {1'b0, v_cnt_q[9:1]} : 10'h3FF;
        mem_col = in_img ? {1'b0, h_off[9:1]} : 10'h3FF;
    end

    always_comb begin
        de0_d = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        hs0_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
        vs0_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    end

    // Stage-0 flags ride one clk beside the memory read so they stay paired with mem_data
    // even when every clk is a pixel.
    always_comb begin
        pix_out_d = pix_out_q;
        de_d      = de_q;
        hsync_n_d = hsync_n_q;
        vsync_n_d = vsync_n_q;
        if (pix_en) begin
            pix_out_d = mem_data;
            de_d      = de0_q;
            hsync_n_d = hs0_q;
            vsync_n_d = vs0_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            de0_q         <= 1'b0;
            hs0_q         <= 1'b1;
            vs0_q         <= 1'b1;
            pix_out_q     <= 8'h3F;
            de_q          <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            frame_start_q <= 1'b0;
            in_vblank_q   <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            de0_q         <= de0_d;
            hs0_q         <= hs0_d;
            vs0_q         <= vs0_d;
            pix_out_q     <= pix_out_d;
            de_q          <= de_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            frame_start_q <= frame_start_d;
            in_vblank_q   <= in_vblank_d;
        end
    end

    assign pix_out     = pix_out_q;
    assign de          = de_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign frame_start = frame_start_q;
    assign in_vblank   = in_vblank_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: full-size timing at CLK_DIV=2 and 1, plus a shrunken
// timing instance so whole frames, vblank and frame_start fit in a short run.
module tb_vga_scan_ctrl;

`ifdef VGA_CENTER_EN
    localparam int X0 = 64;
`else
    localparam int X0 = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst_a = 1'b1, rst_s = 1'b1, rst_c = 1'b1;
    logic [9:0] row_a, col_a, row_s, col_s, row_c, col_c;
    logic [7:0] md_a = 8'h3F, md_s = 8'h3F, md_c = 8'h3F;
    logic [7:0] pix_a, pix_s, pix_c;
    logic       de_a, de_s, de_c, hs_a, hs_s, hs_c, vs_a, vs_s, vs_c;
    logic       fs_a, fs_s, fs_c, vb_a, vb_s, vb_c;

    vga_scan_ctrl #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst_a), .mem_row(row_a), .mem_col(col_a), .mem_data(md_a),
        .pix_out(pix_a), .de(de_a), .hsync_n(hs_a), .vsync_n(vs_a),
        .frame_start(fs_a), .in_vblank(vb_a));

    vga_scan_ctrl #(.CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s (
        .clk(clk), .rst(rst_s), .mem_row(row_s), .mem_col(col_s), .mem_data(md_s),
        .pix_out(pix_s), .de(de_s), .hsync_n(hs_s), .vsync_n(vs_s),
        .frame_start(fs_s), .in_vblank(vb_s));

    vga_scan_ctrl #(.CLK_DIV(1)) dut_c (
        .clk(clk), .rst(rst_c), .mem_row(row_c), .mem_col(col_c), .mem_data(md_c),
        .pix_out(pix_c), .de(de_c), .hsync_n(hs_c), .vsync_n(vs_c),
        .frame_start(fs_c), .in_vblank(vb_c));

    function automatic logic [7:0] mem_f(input logic [9:0] row, input logic [9:0] col);
        if (row == 10'h3FF || col == 10'h3FF) return 8'h3F;
        return {row[3:0], col[3:0]};
    endfunction

    // Frame memory: one clk read latency.
    always @(posedge clk) begin
        md_a <= mem_f(row_a, col_a);
        md_s <= mem_f(row_s, col_s);
        md_c <= mem_f(row_c, col_c);
    end

    function automatic logic in_img(input int h, input int v);
        return (v < 480) && (h >= X0) && (h < X0 + 512);
    endfunction
    function automatic logic [9:0] exp_row(input int h, input int v);
        return in_img(h, v) ? 10'(v / 2) : 10'h3FF;
    endfunction
    function automatic logic [9:0] exp_col(input int h, input int v);
        return in_img(h, v) ? 10'((h - X0) / 2) : 10'h3FF;
    endfunction
    function automatic logic [7:0] exp_pix(input int h, input int v);
        return mem_f(exp_row(h, v), exp_col(h, v));
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (pix_a !== 8'h3F) begin bad++; $display("FAIL reset_pix got=%h exp=3f", pix_a); end
        total++; if (de_a !== 1'b0) begin bad++; $display("FAIL reset_de got=%b exp=0", de_a); end
        total++; if (hs_a !== 1'b1) begin bad++; $display("FAIL reset_hs got=%b exp=1", hs_a); end
        total++; if (vs_a !== 1'b1) begin bad++; $display("FAIL reset_vs got=%b exp=1", vs_a); end
        total++; if (fs_a !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", fs_a); end
        total++; if (vb_a !== 1'b0) begin bad++; $display("FAIL reset_vb got=%b exp=0", vb_a); end
        total++; if (row_a !== exp_row(0, 0)) begin bad++; $display("FAIL reset_row got=%h exp=%h", row_a, exp_row(0, 0)); end
        total++; if (col_a !== exp_col(0, 0)) begin bad++; $display("FAIL reset_col got=%h exp=%h", col_a, exp_col(0, 0)); end
        total++; if (pix_s !== 8'h3F) begin bad++; $display("FAIL reset_s_pix got=%h exp=3f", pix_s); end
        total++; if (vb_s !== 1'b0) begin bad++; $display("FAIL reset_s_vb got=%b exp=0", vb_s); end
    endtask

    // CLK_DIV=2: output pixel n shows after clk edge 2n+1; counters reach n after edge 2n-1.
    task automatic test_scan_a();
        int n, h, v, p, first_hs, de_fall, hs_low;
        logic [7:0] e_pix;
        logic e_de, e_hs, de_prev;
        first_hs = -1; de_fall = -1; hs_low = 0; de_prev = 1'b0;
        @(negedge clk); rst_a = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            n = (k == 0) ? 0 : (k - 1) / 2;
            h = n % 800; v = n / 800;
            e_pix = (k == 0) ? 8'h3F : exp_pix(h, v);
            e_de  = (k != 0) && (h < 640) && (v < 480);
            e_hs  = (k == 0) || !(h >= 656 && h <= 751);
            total++; if (pix_a !== e_pix) begin bad++; $display("FAIL scan_pix k=%0d got=%h exp=%h", k, pix_a, e_pix); end
            total++; if (de_a !== e_de) begin bad++; $display("FAIL scan_de k=%0d got=%b exp=%b", k, de_a, e_de); end
            total++; if (hs_a !== e_hs) begin bad++; $display("FAIL scan_hs k=%0d got=%b exp=%b", k, hs_a, e_hs); end
            total++; if (vs_a !== 1'b1) begin bad++; $display("FAIL scan_vs k=%0d got=%b exp=1", k, vs_a); end
            total++; if (fs_a !== 1'b0) begin bad++; $display("FAIL scan_fs k=%0d got=%b exp=0", k, fs_a); end
            total++; if (vb_a !== 1'b0) begin bad++; $display("FAIL scan_vb k=%0d got=%b exp=0", k, vb_a); end
            p = (k + 1) / 2;
            total++; if (row_a !== exp_row(p % 800, p / 800)) begin bad++; $display("FAIL scan_row k=%0d got=%h exp=%h", k, row_a, exp_row(p % 800, p / 800)); end
            total++; if (col_a !== exp_col(p % 800, p / 800)) begin bad++; $display("FAIL scan_col k=%0d got=%h exp=%h", k, col_a, exp_col(p % 800, p / 800)); end
            if (!hs_a && first_hs < 0) first_hs = k;
            if (de_prev && !de_a && de_fall < 0) de_fall = k;
            if (k <= 1600 && !hs_a) hs_low++;
            de_prev = de_a;
        end
        total++; if (first_hs != 1313) begin bad++; $display("FAIL scan_hs_first got=%0d exp=1313", first_hs); end
        total++; if (de_fall != 1281) begin bad++; $display("FAIL scan_de_fall got=%0d exp=1281", de_fall); end
        total++; if (hs_low != 192) begin bad++; $display("FAIL scan_hs_width got=%0d exp=192", hs_low); end
    endtask

    task automatic test_midline_reset();
        int first_hs, de_fall;
        logic de_prev;
        first_hs = -1; de_fall = -1; de_prev = 1'b0;
        #2 rst_a = 1'b1;
        #1;
        total++; if (pix_a !== 8'h3F) begin bad++; $display("FAIL mrst_pix got=%h exp=3f", pix_a); end
        total++; if (de_a !== 1'b0) begin bad++; $display("FAIL mrst_de got=%b exp=0", de_a); end
        total++; if (hs_a !== 1'b1) begin bad++; $display("FAIL mrst_hs got=%b exp=1", hs_a); end
        total++; if (row_a !== exp_row(0, 0)) begin bad++; $display("FAIL mrst_row got=%h exp=%h", row_a, exp_row(0, 0)); end
        total++; if (col_a !== exp_col(0, 0)) begin bad++; $display("FAIL mrst_col got=%h exp=%h", col_a, exp_col(0, 0)); end
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        for (int k = 0; k <= 1600; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++; if (de_a !== 1'b0) begin bad++; $display("FAIL mrst_de0 got=%b exp=0", de_a); end
            end
            if (k == 1) begin
                total++; if (de_a !== 1'b1) begin bad++; $display("FAIL mrst_first_de got=%b exp=1", de_a); end
                total++; if (pix_a !== exp_pix(0, 0)) begin bad++; $display("FAIL mrst_first_pix got=%h exp=%h", pix_a, exp_pix(0, 0)); end
            end
            total++; if (vb_a !== 1'b0) begin bad++; $display("FAIL mrst_vb k=%0d got=%b exp=0", k, vb_a); end
            total++; if (fs_a !== 1'b0) begin bad++; $display("FAIL mrst_fs k=%0d got=%b exp=0", k, fs_a); end
            if (!hs_a && first_hs < 0) first_hs = k;
            if (de_prev && !de_a && de_fall < 0) de_fall = k;
            de_prev = de_a;
        end
        total++; if (first_hs != 1313) begin bad++; $display("FAIL mrst_hs_first got=%0d exp=1313", first_hs); end
        total++; if (de_fall != 1281) begin bad++; $display("FAIL mrst_de_fall got=%0d exp=1281", de_fall); end
    endtask

    // Shrunken timing: H_TOT=16, V_TOT=8, so a frame is 128 pixels = 256 clk.
    task automatic test_frame_small();
        int n, h, v, p, pulses, first_fs, period;
        logic e_vb, e_fs, e_vs, e_hs, e_de;
        pulses = 0; first_fs = -1; period = -1;
        @(negedge clk); rst_s = 1'b0;
        for (int k = 0; k <= 700; k++) begin
            @(negedge clk);
            p = ((k + 1) / 2) % 128;
            n = (k == 0) ? 0 : ((k - 1) / 2) % 128;
            h = n % 16; v = n / 16;
            e_vb = (p / 16) >= 4;
            e_fs = (k == 255) || (k == 511);
            e_vs = (k == 0) || !(v >= 5 && v <= 6);
            e_hs = (k == 0) || !(h >= 10 && h <= 12);
            e_de = (k != 0) && (h < 8) && (v < 4);
            total++; if (fs_s !== e_fs) begin bad++; $display("FAIL small_fs k=%0d got=%b exp=%b", k, fs_s, e_fs); end
            total++; if (vb_s !== e_vb) begin bad++; $display("FAIL small_vb k=%0d got=%b exp=%b", k, vb_s, e_vb); end
            total++; if (vs_s !== e_vs) begin bad++; $display("FAIL small_vs k=%0d got=%b exp=%b", k, vs_s, e_vs); end
            total++; if (hs_s !== e_hs) begin bad++; $display("FAIL small_hs k=%0d got=%b exp=%b", k, hs_s, e_hs); end
            total++; if (de_s !== e_de) begin bad++; $display("FAIL small_de k=%0d got=%b exp=%b", k, de_s, e_de); end
            if (fs_s) begin
                pulses++;
                if (first_fs < 0) first_fs = k;
                else if (period < 0) period = k - first_fs;
            end
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL small_fs_count got=%0d exp=2", pulses); end
        total++; if (first_fs != 255) begin bad++; $display("FAIL small_fs_first got=%0d exp=255", first_fs); end
        total++; if (period != 256) begin bad++; $display("FAIL small_fs_period got=%0d exp=256", period); end
    endtask

    task automatic test_small_reset();
        int first_vb;
        first_vb = -1;
        total++; if (vb_s !== 1'b1) begin bad++; $display("FAIL srst_pre_vb got=%b exp=1", vb_s); end
        #2 rst_s = 1'b1;
        #1;
        total++; if (vb_s !== 1'b0) begin bad++; $display("FAIL srst_vb got=%b exp=0", vb_s); end
        total++; if (vs_s !== 1'b1) begin bad++; $display("FAIL srst_vs got=%b exp=1", vs_s); end
        total++; if (fs_s !== 1'b0) begin bad++; $display("FAIL srst_fs got=%b exp=0", fs_s); end
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        for (int k = 0; k <= 300; k++) begin
            @(negedge clk);
            total++; if (fs_s !== (k == 255)) begin bad++; $display("FAIL srst_fs k=%0d got=%b exp=%b", k, fs_s, (k == 255)); end
            if (vb_s && first_vb < 0) first_vb = k;
        end
        total++; if (first_vb != 127) begin bad++; $display("FAIL srst_vb_rise got=%0d exp=127", first_vb); end
    endtask

    // CLK_DIV=1: output pixel n shows after clk edge n+1; counters reach n+1 after edge n.
    task automatic test_clkdiv1();
        int n, h, v, p;
        logic e_de;
        @(negedge clk); rst_c = 1'b0;
        for (int k = 0; k < 3300; k++) begin
            @(negedge clk);
            p = k + 1;
            total++; if (col_c !== exp_col(p % 800, p / 800)) begin bad++; $display("FAIL div1_col k=%0d got=%h exp=%h", k, col_c, exp_col(p % 800, p / 800)); end
            if (k >= 1) begin
                n = k - 1; h = n % 800; v = n / 800;
                e_de = (h < 640) && (v < 480);
                total++; if (pix_c !== exp_pix(h, v)) begin bad++; $display("FAIL div1_pix k=%0d got=%h exp=%h", k, pix_c, exp_pix(h, v)); end
                total++; if (de_c !== e_de) begin bad++; $display("FAIL div1_de k=%0d got=%b exp=%b", k, de_c, e_de); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_a();
        test_midline_reset();
        test_frame_small();
        test_small_reset();
        test_clkdiv1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
